// File: rtl/hook_collision.sv
// rtl/hook_collision.sv - hook-to-object collision detector with score accumulation
module hook_collision #(
  parameter int GOLD_SIZE  = 60,
  parameter int DIA_SIZE   = 40,
  parameter int STONE_SIZE = 80,
  parameter int GOLD_VAL   = 100,
  parameter int DIA_VAL    = 500,
  parameter int STONE_VAL  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic [10:0] blk_x,
  input  logic [9:0]  blk_y,
  input  logic [10:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9,
  input  logic [9:0]  y0, y1, y2, y3, y4, y5, y6, y7, y8, y9,
  output logic [3:0]  hitted_gold,
  output logic        hit,
  output logic [1:0]  weight,
  output logic [15:0] score
);

  localparam logic [1:0] WAVING     = 2'b00;
  localparam logic [1:0] STRETCHING = 2'b01;
  localparam logic [1:0] MISSING    = 2'b11;

  localparam logic [1:0] CLS_DIA   = 2'd1;
  localparam logic [1:0] CLS_GOLD  = 2'd2;
  localparam logic [1:0] CLS_STONE = 2'd3;

  localparam logic [3:0] NO_OBJ = 4'hF;

  typedef enum logic [1:0] {IDLE, SCAN, LOCKED} fsm_t;

  fsm_t        fsm, fsm_next;
  logic [3:0]  idx;
  logic [10:0] obj_x;
  logic [9:0]  obj_y;
  logic [11:0] span_x;
  logic [10:0] span_y;
  logic [1:0]  obj_class;
  logic        match;
  logic        latch_hit;
  logic        credit_en;
  logic        scan_step;
  logic [15:0] credit;
  logic [16:0] score_sum;

  // Route the object under test this cycle onto the shared comparator
  always_comb begin
    obj_x = '0;
    obj_y = '0;
    case (idx)
      4'd0: begin obj_x = x0; obj_y = y0; end
      4'd1: begin obj_x = x1; obj_y = y1; end
      4'd2: begin obj_x = x2; obj_y = y2; end
      4'd3: begin obj_x = x3; obj_y = y3; end
      4'd4: begin obj_x = x4; obj_y = y4; end
      4'd5: begin obj_x = x5; obj_y = y5; end
      4'd6: begin obj_x = x6; obj_y = y6; end
      4'd7: begin obj_x = x7; obj_y = y7; end
      4'd8: begin obj_x = x8; obj_y = y8; end
      4'd9: begin obj_x = x9; obj_y = y9; end
      default: begin obj_x = '0; obj_y = '0; end
    endcase
  end

  // Class and box extent of the indexed object
  always_comb begin
    obj_class = CLS_STONE;
    span_x    = 12'(STONE_SIZE - 1);
    span_y    = 11'(STONE_SIZE - 1);
    if (idx < 4'd5) begin
      obj_class = CLS_GOLD;
      span_x    = 12'(GOLD_SIZE - 1);
      span_y    = 11'(GOLD_SIZE - 1);
    end else if (idx < 4'd7) begin
      obj_class = CLS_DIA;
      span_x    = 12'(DIA_SIZE - 1);
      span_y    = 11'(DIA_SIZE - 1);
    end
  end

  // One-bit-wider arithmetic keeps removed objects (x=2000, y=900) from wrapping into view
  always_comb begin
    match = ({1'b0, blk_x} >= {1'b0, obj_x}) &&
            ({1'b0, blk_x} <= ({1'b0, obj_x} + span_x)) &&
            ({1'b0, blk_y} >= {1'b0, obj_y}) &&
            ({1'b0, blk_y} <= ({1'b0, obj_y} + span_y));
  end

  // Value of the latched object and saturating sum for the credit
  always_comb begin
    credit = '0;
    case (weight)
      CLS_DIA:   credit = 16'(DIA_VAL);
      CLS_GOLD:  credit = 16'(GOLD_VAL);
      CLS_STONE: credit = 16'(STONE_VAL);
      default:   credit = '0;
    endcase
    score_sum = {1'b0, score} + {1'b0, credit};
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  // Next state and datapath controls; a match beats waving but not missing
  always_comb begin
    fsm_next  = fsm;
    latch_hit = 1'b0;
    credit_en = 1'b0;
    scan_step = 1'b0;
    case (fsm)
      IDLE: begin
        if (state == STRETCHING) fsm_next = SCAN;
      end
      SCAN: begin
        if (match && state != MISSING) begin
          latch_hit = 1'b1;
          fsm_next  = LOCKED;
        end else if (state == WAVING || state == MISSING) begin
          fsm_next = IDLE;
        end else begin
          scan_step = 1'b1;
        end
      end
      LOCKED: begin
        if (state == WAVING) begin
          credit_en = 1'b1;
          fsm_next  = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Scan index, latched object, hit strobe and score
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      hitted_gold <= NO_OBJ;
      hit         <= 1'b0;
      weight      <= '0;
      score       <= '0;
    end else begin
      hit <= latch_hit;
      if (scan_step) idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
      else           idx <= '0;
      if (latch_hit) begin
        hitted_gold <= idx;
        weight      <= obj_class;
      end else if (credit_en) begin
        hitted_gold <= NO_OBJ;
        weight      <= '0;
        score       <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_hook_collision.sv
// tb/tb_hook_collision.sv - randomized self-checking bench for hook_collision
module tb_hook_collision;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  st;
  logic [10:0] bx;
  logic [9:0]  by;
  logic [10:0] xs [10];
  logic [9:0]  ys [10];
  logic [3:0]  hitted_gold;
  logic        hit;
  logic [1:0]  weight;
  logic [15:0] score;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state: 0 idle, 1 scanning, 2 holding an object
  int m_mode = 0;
  int m_k = 0;
  int m_obj = -1;
  int m_hit = 0;
  int m_score = 0;

  hook_collision dut (
    .clk(clk), .rst(rst), .state(st), .blk_x(bx), .blk_y(by),
    .x0(xs[0]), .x1(xs[1]), .x2(xs[2]), .x3(xs[3]), .x4(xs[4]),
    .x5(xs[5]), .x6(xs[6]), .x7(xs[7]), .x8(xs[8]), .x9(xs[9]),
    .y0(ys[0]), .y1(ys[1]), .y2(ys[2]), .y3(ys[3]), .y4(ys[4]),
    .y5(ys[5]), .y6(ys[6]), .y7(ys[7]), .y8(ys[8]), .y9(ys[9]),
    .hitted_gold(hitted_gold), .hit(hit), .weight(weight), .score(score)
  );

  initial forever #5 clk = ~clk;

  function automatic int size_of(int k);
    if (k < 5) return 60;
    if (k < 7) return 40;
    return 80;
  endfunction

  function automatic int class_of(int k);
    if (k < 0) return 0;
    if (k < 5) return 2;
    if (k < 7) return 1;
    return 3;
  endfunction

  function automatic int value_of(int k);
    if (k < 5) return 100;
    if (k < 7) return 500;
    return 20;
  endfunction

  function automatic bit in_box(int k);
    int ox, oy, s;
    ox = int'(xs[k]);
    oy = int'(ys[k]);
    s  = size_of(k);
    return (int'(bx) >= ox) && (int'(bx) <= ox + s - 1) &&
           (int'(by) >= oy) && (int'(by) <= oy + s - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: scan position advances one object per clock from 0
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_k = 0; m_obj = -1; m_hit = 0; m_score = 0;
    end else begin
      m_hit = 0;
      if (m_mode == 0) begin
        if (st == 2'b01) begin m_mode = 1; m_k = 0; end
      end else if (m_mode == 1) begin
        if (st != 2'b11 && in_box(m_k)) begin
          m_obj = m_k; m_hit = 1; m_mode = 2;
        end else if (st == 2'b00 || st == 2'b11) begin
          m_mode = 0;
        end else begin
          m_k = (m_k + 1) % 10;
        end
      end else begin
        if (st == 2'b00) begin
          m_score = m_score + value_of(m_obj);
          if (m_score > 65535) m_score = 65535;
          m_obj = -1;
          m_mode = 0;
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle out of reset
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("hitted_gold", int'(hitted_gold), (m_obj < 0) ? 15 : m_obj);
      chk("hit", int'(hit), m_hit);
      chk("weight", int'(weight), class_of(m_obj));
      chk("score", int'(score), m_score);
    end
  end

  task automatic clear_objs();
    for (int i = 0; i < 10; i++) begin
      xs[i] = 11'd2000;
      ys[i] = 10'd900;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hit(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (hit === 1'b1) begin
        c = i;
        break;
      end
    end
  endtask

  int c, hits, n, k, len, base_score;

  initial begin
    rst = 1'b1; st = 2'b00; bx = '0; by = '0;
    clear_objs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hitted_gold", int'(hitted_gold), 15);
    chk("rst_hit", int'(hit), 0);
    chk("rst_weight", int'(weight), 0);
    chk("rst_score", int'(score), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);

    // diamond hit: object 5 compared 5 cycles after entry, visible one edge later
    xs[5] = 11'd300; ys[5] = 10'd200; bx = 11'd339; by = 10'd239;
    st = 2'b01;
    wait_hit(20, c);
    chk("dia_latency", c, 6);
    chk("dia_index", int'(hitted_gold), 5);
    chk("dia_weight", int'(weight), 1);
    st = 2'b10;
    cyc(3);
    chk("dia_hold", int'(hitted_gold), 5);
    st = 2'b00;
    cyc(1);
    chk("dia_score", int'(score), 500);
    chk("dia_model_score", m_score, 500);
    chk("dia_cleared", int'(hitted_gold), 15);
    cyc(1);

    // box edges: one pixel right of the diamond misses, its top-left corner hits
    bx = 11'd340; by = 10'd239;
    st = 2'b01;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hit === 1'b1) hits++;
    end
    chk("edge_outside_hits", hits, 0);
    bx = 11'd300; by = 10'd200;
    wait_hit(12, c);
    chk("edge_corner_hit", int'(c >= 0), 1);
    chk("edge_corner_index", int'(hitted_gold), 5);
    st = 2'b00;
    cyc(2);

    // wrap guard: removed objects must never match a tip near the origin
    clear_objs();
    bx = 11'd31; by = 10'd50;
    base_score = int'(score);
    st = 2'b01;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hit === 1'b1) hits++;
    end
    chk("wrap_hits", hits, 0);
    st = 2'b11;
    cyc(2);
    chk("wrap_score", int'(score), base_score);
    chk("wrap_index", int'(hitted_gold), 15);
    st = 2'b00;
    cyc(1);

    // overlap: gold 2 is reached before stone 8
    clear_objs();
    xs[8] = 11'd100; ys[8] = 10'd100;
    xs[2] = 11'd120; ys[2] = 10'd120;
    bx = 11'd130; by = 10'd130;
    base_score = int'(score);
    st = 2'b01;
    wait_hit(12, c);
    chk("ovl_latency", c, 3);
    chk("ovl_index", int'(hitted_gold), 2);
    chk("ovl_weight", int'(weight), 2);
    st = 2'b00;
    cyc(1);
    chk("ovl_score", int'(score), base_score + 100);
    cyc(1);

    // randomized layouts, tip moves and state changes
    for (int t = 0; t < 40; t++) begin
      clear_objs();
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        k = $urandom_range(0, 9);
        xs[k] = 11'($urandom_range(0, 1800));
        ys[k] = 10'($urandom_range(0, 780));
      end
      k = $urandom_range(0, 9);
      if (xs[k] != 11'd2000 && $urandom_range(0, 3) != 0) begin
        bx = 11'(int'(xs[k]) + $urandom_range(0, size_of(k) - 1));
        by = 10'(int'(ys[k]) + $urandom_range(0, size_of(k) - 1));
      end else begin
        bx = 11'($urandom_range(0, 1900));
        by = 10'($urandom_range(0, 880));
      end
      st = 2'b01;
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if ($urandom_range(0, 4) == 0) begin
          bx = 11'($urandom_range(0, 1900));
          by = 10'($urandom_range(0, 880));
        end
        if ($urandom_range(0, 9) == 0) st = 2'b10;
      end
      st = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
      cyc(1);
      st = 2'b00;
      cyc(2);
    end

    // asynchronous reset mid-scan with a nonzero score
    clear_objs();
    xs[5] = 11'd300; ys[5] = 10'd200; bx = 11'd10; by = 10'd10;
    st = 2'b01;
    cyc(4);
    chk("pre_rst_score_nonzero", int'(score != 16'd0), 1);
    #2 rst = 1'b1;
    #1;
    chk("scan_rst_hitted_gold", int'(hitted_gold), 15);
    chk("scan_rst_hit", int'(hit), 0);
    chk("scan_rst_score", int'(score), 0);
    @(negedge clk);
    rst = 1'b0;
    st = 2'b00;
    cyc(1);

    // asynchronous reset while an object is held
    bx = 11'd320; by = 10'd220;
    st = 2'b01;
    wait_hit(12, c);
    chk("lock_hit_seen", int'(c >= 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("lock_rst_hitted_gold", int'(hitted_gold), 15);
    chk("lock_rst_weight", int'(weight), 0);
    @(negedge clk);
    rst = 1'b0;
    st = 2'b00;
    cyc(1);

    // saturation: 131 diamonds reach 65500, one more clamps at 65535
    for (int i = 0; i < 131; i++) begin
      st = 2'b01;
      wait_hit(12, c);
      if (c < 0) chk("sat_hit_timeout", c, 6);
      st = 2'b00;
      cyc(1);
    end
    chk("sat_pre", int'(score), 65500);
    st = 2'b01;
    wait_hit(12, c);
    chk("sat_last_hit", int'(c >= 0), 1);
    st = 2'b00;
    cyc(1);
    chk("sat_score", int'(score), 65535);
    cyc(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
